// File: rtl/period_tracking_trigger_if.sv
// rtl/period_tracking_trigger_if.sv - control/status bundle for period_tracking_trigger
// Optional member period_missed exists only when PERIOD_TRACKING_TRIGGER_MISSED_EN is defined.
interface period_tracking_trigger_if #(
   parameter int COUNTER_WIDTH    = 32,
   parameter int PRESAMPLES_WIDTH = 32,
   parameter int ADC_WIDTH        = 16,
   parameter int NUM_ADC          = 2,
   parameter int NUM_DIO          = 8
);
   logic                              enable;
   logic                              trigger_arm;
   logic                              trigger_reset;
   logic [NUM_DIO-1:0]                dios;
   logic [NUM_ADC*ADC_WIDTH-1:0]      adcs;
   logic                              source_is_adc;
   logic [3:0]                        source_index;
   logic [1:0]                        edge_mode;
   logic [ADC_WIDTH-2:0]              hysteresis;
   logic                              use_average;
   logic [PRESAMPLES_WIDTH-1:0]       trigger_presamples;
   logic [COUNTER_WIDTH-1:0]          reference_counter;
   logic                              trigger;
   logic                              trigger_armed;
   logic [COUNTER_WIDTH-1:0]          last_counter;
   logic [COUNTER_WIDTH-1:0]          avg_counter;
   logic                              period_valid;
`ifdef PERIOD_TRACKING_TRIGGER_MISSED_EN
   logic                              period_missed;
`endif

   modport master (
`ifdef PERIOD_TRACKING_TRIGGER_MISSED_EN
      input  period_missed,
`endif
      output enable, trigger_arm, trigger_reset, dios, adcs, source_is_adc, source_index,
             edge_mode, hysteresis, use_average, trigger_presamples, reference_counter,
      input  trigger, trigger_armed, last_counter, avg_counter, period_valid
   );

   modport slave (
`ifdef PERIOD_TRACKING_TRIGGER_MISSED_EN
      output period_missed,
`endif
      input  enable, trigger_arm, trigger_reset, dios, adcs, source_is_adc, source_index,
             edge_mode, hysteresis, use_average, trigger_presamples, reference_counter,
      output trigger, trigger_armed, last_counter, avg_counter, period_valid
   );
endinterface

// File: rtl/period_tracking_trigger.sv
// rtl/period_tracking_trigger.sv - period-tracking pre-event trigger with DIO/ADC source selection
// Optional missed-period detector: PERIOD_TRACKING_TRIGGER_MISSED_EN.
module period_tracking_trigger #(
   parameter int COUNTER_WIDTH    = 32,
   parameter int PRESAMPLES_WIDTH = 32,
   parameter int ADC_WIDTH        = 16,
   parameter int NUM_ADC          = 2,
   parameter int NUM_DIO          = 8,
   parameter int AVG_LOG2         = 2
) (
   input logic                      clk,
   input logic                      areset,
   period_tracking_trigger_if.slave bus
);
   localparam int CW    = COUNTER_WIDTH;
   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SW    = CW + AVG_LOG2;
   localparam int TW    = ((CW > PRESAMPLES_WIDTH) ? CW : PRESAMPLES_WIDTH) + 1;
   localparam int HCW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  CNT_MAX   = '1;
   localparam logic [HCW-1:0] HIST_FULL = HCW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PENDING, S_ARMED, S_FIRED} state_t;

   logic                        w_dio_bit;
   logic signed [ADC_WIDTH-1:0] w_sample, w_hyst_pos, w_hyst_neg;
   logic                        w_level_next, w_rise, w_fall, w_edge;
   logic [6:0]                  w_cfg;
   logic                        w_cfg_chg, w_record, w_avg_upd, w_valid;
   logic [CW-1:0]               w_counter_inc, w_ref, w_thr;
   logic [TW-1:0]               w_lead;
   logic                        w_ref_ok, w_fresh;

   logic                        r_level, r_level_vld, r_prev_level, r_prev_vld, r_event;
   logic [6:0]                  r_cfg;
   logic                        r_seen;
   logic [CW-1:0]               r_counter, r_last, r_avg;
   logic [CW-1:0]               r_hist [DEPTH];
   logic [SW-1:0]               r_sum;
   logic [HCW-1:0]              r_hist_cnt;
   state_t                      r_state;
   logic                        r_trigger, r_armed;

   // Channel selection; an out-of-range index falls back to channel 0.
   always_comb begin
      w_dio_bit = bus.dios[0];
      w_sample  = bus.adcs[ADC_WIDTH-1:0];
      for (int k = 1; k < NUM_DIO; k++)
         if (bus.source_index == 4'(k)) w_dio_bit = bus.dios[k];
      for (int k = 1; k < NUM_ADC; k++)
         if (bus.source_index == 4'(k)) w_sample = bus.adcs[k*ADC_WIDTH +: ADC_WIDTH];
   end

   assign w_hyst_pos = signed'({1'b0, bus.hysteresis});
   assign w_hyst_neg = -w_hyst_pos;

   // Next source level: DIO line directly, ADC through a Schmitt window (zero window means sample >= 0).
   always_comb begin
      w_level_next = r_level;
      if (!bus.source_is_adc)             w_level_next = w_dio_bit;
      else if (w_sample > w_hyst_pos)     w_level_next = 1'b1;
      else if (w_sample < w_hyst_neg)     w_level_next = 1'b0;
      else if (bus.hysteresis == '0)      w_level_next = 1'b1;
   end

   assign w_rise    = r_level & ~r_prev_level;
   assign w_fall    = ~r_level & r_prev_level;
   assign w_edge    = (bus.edge_mode == 2'b00) ? w_rise :
                      (bus.edge_mode == 2'b01) ? w_fall : (w_rise | w_fall);
   assign w_cfg     = {bus.source_is_adc, bus.source_index, bus.edge_mode};
   assign w_cfg_chg = (w_cfg != r_cfg);

   // Level capture and edge detection; prev_vld keeps the first captured level from making an event.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_level <= 1'b0; r_level_vld <= 1'b0; r_prev_level <= 1'b0;
         r_prev_vld <= 1'b0; r_event <= 1'b0; r_cfg <= '0;
      end else if (!bus.enable) begin
         r_level <= 1'b0; r_level_vld <= 1'b0; r_prev_level <= 1'b0;
         r_prev_vld <= 1'b0; r_event <= 1'b0; r_cfg <= '0;
      end else begin
         r_level      <= w_level_next;
         r_level_vld  <= 1'b1;
         r_prev_level <= r_level;
         r_prev_vld   <= r_level_vld;
         r_event      <= r_prev_vld & w_edge;
         r_cfg        <= w_cfg;
      end
   end

   assign w_counter_inc = (r_counter == CNT_MAX) ? r_counter : r_counter + CW'(1);
   assign w_record      = r_event & r_seen & ~w_cfg_chg;
   assign w_valid       = (r_hist_cnt == HIST_FULL);

   // Period counter, last period, and running-sum history for the average.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_counter <= '0; r_last <= '0; r_avg <= '0; r_sum <= '0; r_hist_cnt <= '0; r_seen <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
      end else if (!bus.enable) begin
         r_counter <= '0; r_last <= '0; r_avg <= '0; r_sum <= '0; r_hist_cnt <= '0; r_seen <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
      end else begin
         r_counter <= (bus.trigger_reset || r_event) ? '0 : w_counter_inc;
         if (w_cfg_chg)    r_seen <= 1'b0;
         else if (r_event) r_seen <= 1'b1;
         if (w_record) begin
            r_last <= w_counter_inc;
            if (w_avg_upd) begin
               r_hist[0] <= w_counter_inc;
               for (int i = DEPTH - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
               r_sum <= r_sum + SW'(w_counter_inc) - SW'(r_hist[DEPTH-1]);
               if (r_hist_cnt != HIST_FULL) r_hist_cnt <= r_hist_cnt + HCW'(1);
            end
         end
         r_avg <= r_sum[AVG_LOG2 +: CW];
      end
   end

`ifdef PERIOD_TRACKING_TRIGGER_MISSED_EN
   logic r_missed, r_skip_avg, w_missed_now;
   assign w_missed_now = (w_ref != '0) && ({1'b0, r_counter} > {w_ref, 1'b0});

   // Sticky missed-period flag; the next recorded period is kept out of the average.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_missed <= 1'b0; r_skip_avg <= 1'b0;
      end else if (!bus.enable) begin
         r_missed <= 1'b0; r_skip_avg <= 1'b0;
      end else begin
         if (bus.trigger_reset) r_missed <= 1'b0;
         else if (w_missed_now) r_missed <= 1'b1;
         if (w_record)          r_skip_avg <= 1'b0;
         else if (w_missed_now) r_skip_avg <= 1'b1;
      end
   end
   assign w_avg_upd         = ~r_skip_avg;
   assign bus.period_missed = r_missed;
`else
   assign w_avg_upd = 1'b1;
`endif

   // Threshold at full width so a lead longer than the reference clamps to 0 instead of wrapping.
   assign w_ref    = bus.use_average ? r_avg : bus.reference_counter;
   assign w_lead   = TW'(bus.trigger_presamples) + TW'(1);
   assign w_thr    = (w_lead >= TW'(w_ref)) ? '0 : CW'(TW'(w_ref) - w_lead);
   assign w_ref_ok = ~bus.use_average | w_valid;
   // A just-restarted counter counts as fresh, so a zero threshold can still be armed.
   assign w_fresh  = (r_counter < w_thr) || (r_counter == '0);

   // Arming FSM with registered trigger/armed outputs; trigger_reset dominates everything.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state <= S_IDLE; r_trigger <= 1'b0; r_armed <= 1'b0;
      end else if (!bus.enable || bus.trigger_reset) begin
         r_state <= S_IDLE; r_trigger <= 1'b0; r_armed <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:    if (bus.trigger_arm) r_state <= S_PENDING;
            S_PENDING: if (w_ref_ok && w_fresh) begin
                          r_state <= S_ARMED;
                          r_armed <= 1'b1;
                       end
            S_ARMED:   if (!r_event && r_counter >= w_thr) begin
                          r_state   <= S_FIRED;
                          r_trigger <= 1'b1;
                          r_armed   <= 1'b0;
                       end
            S_FIRED:   r_trigger <= 1'b1;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.trigger       = r_trigger | ~bus.enable;
   assign bus.trigger_armed = r_armed;
   assign bus.last_counter  = r_last;
   assign bus.avg_counter   = r_avg;
   assign bus.period_valid  = w_valid;
endmodule

// File: doc/period_tracking_trigger.md
Name: period_tracking_trigger

Overview:
- Parametrised successor to the counter-delayed trigger: measures the period between events on a selectable DIO or ADC channel and fires a trigger a programmable number of samples before the next expected event.
- Adds N-channel source selection, edge-mode selection, ADC hysteresis, and an internal running average over 2^AVG_LOG2 periods as an alternative reference.
- Sits in the acquisition trigger path; its output is AND-ed with the other trigger sources.

Parameters:
- COUNTER_WIDTH, 32, width of the period counter, reference and outputs.
- PRESAMPLES_WIDTH, 32, width of trigger_presamples.
- ADC_WIDTH, 16, signed ADC sample width.
- NUM_ADC, 2, number of ADC channels, 1..16.
- NUM_DIO, 8, number of DIO lines, 1..16.
- AVG_LOG2, 2, log2 of the averaging depth, 0..4.

Ports:
- clk  in  1  sample clock.
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  block enable.
- trigger_arm  in  1  arm request; a 1-cycle pulse is sufficient.
- trigger_reset  in  1  disarm and clear trigger; dominant over every other input.
- dios  in  NUM_DIO  digital sources.
- adcs  in  NUM_ADC*ADC_WIDTH  packed signed samples; channel k occupies bits [k*ADC_WIDTH +: ADC_WIDTH].
- source_is_adc  in  1  0 selects DIO, 1 selects ADC.
- source_index  in  4  channel index; an out-of-range index selects channel 0.
- edge_mode  in  2  00 rising, 01 falling, 10/11 both edges.
- hysteresis  in  ADC_WIDTH-1  unsigned ADC threshold magnitude.
- use_average  in  1  1 uses avg_counter as the reference, 0 uses reference_counter.
- trigger_presamples  in  PRESAMPLES_WIDTH  lead, in samples, before the expected event.
- reference_counter  in  COUNTER_WIDTH  externally supplied period reference.
- trigger  out  1  trigger output.
- trigger_armed  out  1  high in the ARMED state.
- last_counter  out  COUNTER_WIDTH  most recent full period, in cycles.
- avg_counter  out  COUNTER_WIDTH  mean of the last 2^AVG_LOG2 periods.
- period_valid  out  1  high once the averaging history is full.

Behaviour:
- Reset state (areset=1, or enable=0): all registers cleared; trigger=~enable, so a disabled block never masks the AND-ed trigger; trigger_armed=0; last_counter=0; avg_counter=0; period_valid=0.
- Source level, registered at cycle n:
  - DIO: the selected line.
  - ADC: Schmitt state. Set when the sample is greater than +hysteresis; cleared when it is less than -hysteresis; otherwise held. With hysteresis=0, level = (sample >= 0).
- Event detection: at cycle n+1, the current level is compared with the previous level and an event pulse is registered according to edge_mode. Input-to-event latency is 2 cycles.
- The first detected level after enable only initialises the previous level and generates no event.
- Period counter:
  - Increments each cycle and saturates at all-ones; it does not wrap.
  - On an event: last_counter <= counter+1 (saturating), then counter <= 0.
  - The first event after enable only zeroes the counter; no period is recorded.
  - trigger_reset also zeroes the counter.
- Averaging:
  - A shift-register history of 2^AVG_LOG2 periods feeds a running sum of width COUNTER_WIDTH+AVG_LOG2. On each recorded period: sum <= sum + new - oldest.
  - avg_counter = sum >> AVG_LOG2, registered, valid 1 cycle after last_counter updates.
  - period_valid rises once 2^AVG_LOG2 periods have been recorded.
- Threshold: ref = use_average ? avg_counter : reference_counter. thr = ref - trigger_presamples - 1, saturated at 0 when trigger_presamples+1 >= ref. This is computed at full width with no underflow wrap.
- Arming FSM:
  - IDLE: trigger_arm moves to PENDING.
  - PENDING: moves to ARMED on the first cycle with counter < thr, so the block never fires on a stale, already-satisfied condition.
  - ARMED: moves to FIRED when counter >= thr; trigger <= 1 on that transition.
  - FIRED: trigger held at 1 until trigger_reset.
- trigger_reset in any state: next state IDLE, trigger <= 0, counter <= 0. trigger_arm asserted in the same cycle is ignored.
- When use_average=1 and period_valid=0, PENDING does not advance.
- An event while ARMED does not fire; the counter restarts and the block stays ARMED.
- Changing the source or edge mode mid-operation clears the first-event flag: the first event after the change only zeroes the counter, and the history is preserved.

Optional Feature:
- Macro: PERIOD_TRACKING_TRIGGER_MISSED_EN.
- Defined: adds output port period_missed (1 bit, sticky). It is set when counter exceeds 2*ref (saturating) while ref is nonzero, and cleared by trigger_reset or reset. A missed period also suppresses the averaging update for the next recorded period.
- Undefined: the port is absent and no logic is built.

Test Plan:
- DIO 0, rising edges every 100 cycles, reference_counter=100, presamples=10, arm -> last_counter=100; trigger rises when counter=89, 11 cycles before the edge; trigger_armed=1 before firing.
- ADC 1, sine period 64 cycles, hysteresis=0x100, edge_mode=10, use_average=1, AVG_LOG2=2 -> events every 32 cycles; period_valid after the 4th recorded period; avg_counter=32.
- Arm while counter already exceeds thr (ref=50, presamples=0, counter=60) -> no fire until the next event and a later counter=49.
- trigger_reset and trigger_arm in the same cycle while FIRED -> trigger=0 next cycle, state IDLE, arm ignored.
- presamples=200, ref=100 -> thr=0; block fires in the first cycle with counter >= 0 after reaching ARMED; no wrap-induced misbehaviour.
- enable=0, then areset pulse mid-period -> trigger=1, all outputs 0; after re-enable, the first edge records no period.
